uart_rx_deserializer: RTL and testbench

//  UART receiver: the receive end of the Tx path's 8N1 serial link (9600 bps at 48 MHz clk).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_deserializer_if.sv | 21 ++
 rtl/rx_sync_2ff.sv | 21 ++
 rtl/uart_rx_deserializer.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link constants.
// The default constants are common to the Tx and Rx sides of the link.
package uart_pkg;

  localparam int DEFAULT_CLOCKS_PER_BIT = 5000;  // 48 MHz / 9600 bps
  localparam int DEFAULT_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Parallel-side bundle of the UART receiver. The master drives it and the slave consumes it.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_deserializer_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 framing_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (output rx_data, rx_valid, framing_err, busy, parity_err);
  modport slave  (input  rx_data, rx_valid, framing_err, busy, parity_err);
`else
  modport master (output rx_data, rx_valid, framing_err, busy);
  modport slave  (input  rx_data, rx_valid, framing_err, busy);
`endif
endinterface

// File: rtl/rx_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rx line. It resets to the idle-high level.
module rx_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);
  logic meta;

  // NOTE: sequential state uses non-blocking (<=) so both flops sample the pre-edge values;
  // blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver: centre-samples each bit and emits one byte per frame with framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int DATA_BITS      = DEFAULT_DATA_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  uart_rx_deserializer_if.master rx_out
);
  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state,       state_next;
  logic [CNT_W-1:0]     cnt,         cnt_next;
  logic [IDX_W-1:0]     bit_idx,     bit_idx_next;
  logic [DATA_BITS-1:0] shreg,       shreg_next;
  logic [DATA_BITS-1:0] rx_data,     rx_data_next;
  logic                 rx_valid,    rx_valid_next;
  logic                 framing_err, framing_err_next;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad,     par_bad_next;
  logic                 parity_err,  parity_err_next;
`endif

  rx_sync_2ff u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (rx),
    .sync_out (rx_s)
  );

  // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    bit_idx_next     = bit_idx;
    shreg_next       = shreg;
    rx_data_next     = rx_data;
    rx_valid_next    = 1'b0;
    framing_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next     = par_bad;
    parity_err_next  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // A start bit that has gone high again by mid-bit is a glitch and is dropped.
        if (cnt == CNT_HALF) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_next     = '0;
          par_bad_next = (^shreg) ^ rx_s;
          state_next   = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            rx_data_next    = shreg;
            rx_valid_next   = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_next = par_bad;
`endif
            state_next      = IDLE;
          end else begin
            framing_err_next = 1'b1;
            state_next       = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line returns high so a break cannot look like a start bit.
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shreg       <= shreg_next;
      rx_data     <= rx_data_next;
      rx_valid    <= rx_valid_next;
      framing_err <= framing_err_next;
`ifdef UART_RX_PARITY_EN
      par_bad     <= par_bad_next;
      parity_err  <= parity_err_next;
`endif
    end
  end

  assign rx_out.rx_data     = rx_data;
  assign rx_out.rx_valid    = rx_valid;
  assign rx_out.framing_err = framing_err;
  assign rx_out.busy        = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_out.parity_err  = parity_err;
`endif
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer with CLOCKS_PER_BIT=8. Expected bytes are queued when a frame is driven.
// The bench checks each queued byte when the receiver raises its rx_valid pulse.
module tb_uart_rx_deserializer;
  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;

  uart_rx_deserializer_if #(.DATA_BITS(8)) rx_bus ();

  uart_rx_deserializer #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .rx_out (rx_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0, cyc = 0, n_valid = 0, n_fe = 0;
  int   last_valid_cyc = -1, prev_valid_cyc = -1;
  logic prev_valid = 1'b0, prev_pulse = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were set before the edge; outputs are sampled 1 ns after it.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_valid) check("busy_after_valid", 32'(rx_bus.busy), 0);
    if (rx_bus.rx_valid || rx_bus.framing_err) begin
      check("pulse_exclusive", 32'(rx_bus.rx_valid & rx_bus.framing_err), 0);
      check("pulse_not_consecutive", 32'(prev_pulse), 0);
    end
    if (rx_bus.rx_valid) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      check("valid_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_bus.rx_data), 32'(e.data));
`ifdef UART_RX_PARITY_EN
        check("parity_err", 32'(rx_bus.parity_err), 32'(e.perr));
`endif
      end
    end
`ifdef UART_RX_PARITY_EN
    if (rx_bus.parity_err) check("parity_err_alone", 32'(rx_bus.rx_valid), 1);
`endif
    if (rx_bus.framing_err) n_fe++;
    prev_valid = rx_bus.rx_valid;
    prev_pulse = rx_bus.rx_valid | rx_bus.framing_err;
  endtask

  task automatic drive_bit(logic b);
    rx = b;
    repeat (CPB) cycle();
  endtask

  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic send_frame(logic [7:0] d, logic stop_bit, logic par_bit);
    exp_t e;
    e.data = d;
    e.perr = (^d) ^ par_bit;
    if (stop_bit) exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  initial begin
    int         v0, f0;
    logic [7:0] d55;
    d55 = 8'h55;

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) cycle();
    check("reset_busy",        32'(rx_bus.busy), 0);
    check("reset_rx_valid",    32'(rx_bus.rx_valid), 0);
    check("reset_framing_err", 32'(rx_bus.framing_err), 0);
    check("reset_rx_data",     32'(rx_bus.rx_data), 0);
`ifdef UART_RX_PARITY_EN
    check("reset_parity_err",  32'(rx_bus.parity_err), 0);
`endif
    reset = 1'b0;
    idle(4);

    // 1) Single frame 0xA5
    v0 = n_valid; f0 = n_fe;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(6);
    check("t1_valid_count", n_valid - v0, 1);
    check("t1_framing_err", n_fe - f0, 0);
    check("t1_rx_data",     32'(rx_bus.rx_data), 32'h A5);
    check("t1_busy_idle",   32'(rx_bus.busy), 0);

    // 2) Short low glitch aborts in START
    v0 = n_valid; f0 = n_fe;
    rx = 1'b0;
    repeat (3) cycle();
    check("t2_busy_in_start", 32'(rx_bus.busy), 1);
    idle(10);
    check("t2_busy_idle",   32'(rx_bus.busy), 0);
    check("t2_valid_count", n_valid - v0, 0);
    check("t2_framing_err", n_fe - f0, 0);
    check("t2_rx_data",     32'(rx_bus.rx_data), 32'h A5);

    // 3) Stop bit low followed by a break
    v0 = n_valid; f0 = n_fe;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    rx = 1'b0;
    repeat (20) cycle();
    check("t3_framing_count", n_fe - f0, 1);
    check("t3_busy_in_break", 32'(rx_bus.busy), 1);
    check("t3_valid_count",   n_valid - v0, 0);
    rx = 1'b1;
    cycle();
    check("t3_busy_held",     32'(rx_bus.busy), 1);
    repeat (3) cycle();
    check("t3_busy_released", 32'(rx_bus.busy), 0);
    check("t3_framing_once",  n_fe - f0, 1);
    check("t3_rx_data",       32'(rx_bus.rx_data), 32'h A5);

    // 4) Back-to-back frames with no idle bits
    v0 = n_valid;
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle(6);
    check("t4_valid_count", n_valid - v0, 2);
    check("t4_valid_gap",   last_valid_cyc - prev_valid_cyc, FRAME_BITS * CPB);
    check("t4_rx_data",     32'(rx_bus.rx_data), 32'h FF);

    // 5) Reset during data bit 4, then a clean frame
    v0 = n_valid; f0 = n_fe;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d55[i]);
    rx = d55[4];
    repeat (CPB / 2) cycle();
    check("t5_busy_mid_frame", 32'(rx_bus.busy), 1);
    reset = 1'b1;
    cycle();
    check("t5_busy_after_reset",    32'(rx_bus.busy), 0);
    check("t5_rx_data_after_reset", 32'(rx_bus.rx_data), 0);
    reset = 1'b0;
    idle(6);
    check("t5_no_valid", n_valid - v0, 0);
    check("t5_no_fe",    n_fe - f0, 0);
    check("t5_busy",     32'(rx_bus.busy), 0);
    send_frame(d55, 1'b1, ^d55);
    idle(6);
    check("t5_valid_count", n_valid - v0, 1);
    check("t5_rx_data",     32'(rx_bus.rx_data), 32'h 55);

`ifdef UART_RX_PARITY_EN
    // 6) Even parity: 0x07 has three ones, so parity bit 1 is correct
    v0 = n_valid;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(6);
    check("t6_valid_count", n_valid - v0, 2);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
